// File: rtl/alu_sequencer.sv
// alu_sequencer: start/busy/done front end for the external ALU with an iterative signed MUL/DIV engine
module alu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_start,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] out_alu_a,
    output logic [WIDTH-1:0] out_alu_b,
    output logic [WIDTH-1:0] out_alu_opcode,
    input  logic [WIDTH-1:0] in_alu_result,
    output logic             out_busy,
    output logic             out_done,
    output logic [WIDTH-1:0] out_hi,
    output logic [WIDTH-1:0] out_lo,
    output logic             out_div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;

    typedef enum logic [2:0] {S_IDLE, S_ALU, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]         alu_op_q, alu_op_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               dbz_q, dbz_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d, sa_q, sa_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] mul_sum, mul_res;
    logic [WIDTH+1:0]   div_try;
    logic               div_fit;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_acc;
    logic [WIDTH-1:0]   div_q, div_r;

    // MUL: acc holds the running magnitude product; mcand shifts left, mplier shifts right.
    // DIV: acc holds {partial remainder, dividend bits shifting into quotient}; mcand low word is |divisor|.
    assign abs_a   = in_a[WIDTH-1] ? -in_a : in_a;
    assign abs_b   = in_b[WIDTH-1] ? -in_b : in_b;
    assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_res = neg_q ? -mul_sum : mul_sum;
    assign div_try = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, mcand_q[WIDTH-1:0]};
    assign div_fit = ~div_try[WIDTH+1];
    assign div_rem = div_fit ? div_try[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1];
    assign div_acc = {div_rem, acc_q[WIDTH-2:0], div_fit};
    assign div_q   = neg_q ? -div_acc[WIDTH-1:0] : div_acc[WIDTH-1:0];
    assign div_r   = sa_q ? -div_acc[2*WIDTH-1:WIDTH] : div_acc[2*WIDTH-1:WIDTH];

    assign out_alu_a       = alu_a_q;
    assign out_alu_b       = alu_b_q;
    assign out_alu_opcode  = {{(WIDTH-4){1'b0}}, alu_op_q};
    assign out_busy        = (state_q == S_ALU) || (state_q == S_MUL) || (state_q == S_DIV);
    assign out_done        = (state_q == S_DONE);
    assign out_hi          = hi_q;
    assign out_lo          = lo_q;
    assign out_div_by_zero = dbz_q;

    // Next-state: accept in IDLE/DONE, step the MUL/DIV engine, capture results on completion
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        sa_d     = sa_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (in_start) begin
                    neg_d = in_a[WIDTH-1] ^ in_b[WIDTH-1];
                    sa_d  = in_a[WIDTH-1];
                    if (in_opcode == OP_MUL) begin
                        state_d  = S_MUL;
                        cnt_d    = CW'(WIDTH - 1);
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, abs_a};
                        mplier_d = abs_b;
                    end else if (in_opcode == OP_DIV && in_b != '0) begin
                        state_d = S_DIV;
                        cnt_d   = CW'(WIDTH - 1);
                        acc_d   = {{WIDTH{1'b0}}, abs_a};
                        mcand_d = {{WIDTH{1'b0}}, abs_b};
                    end else if (in_opcode == OP_DIV) begin
                        state_d = S_DONE;
                        lo_d    = '1;
                        hi_d    = in_a;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d  = S_ALU;
                        alu_a_d  = in_a;
                        alu_b_d  = in_b;
                        alu_op_d = in_opcode;
                    end
                end
            end
            S_ALU: begin
                state_d = S_DONE;
                lo_d    = in_alu_result;
                hi_d    = '0;
                dbz_d   = 1'b0;
            end
            S_MUL: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    hi_d    = mul_res[2*WIDTH-1:WIDTH];
                    lo_d    = mul_res[WIDTH-1:0];
                    dbz_d   = 1'b0;
                end
            end
            S_DIV: begin
                acc_d = div_acc;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    hi_d    = div_r;
                    lo_d    = div_q;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation and clears all results
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            sa_q     <= sa_d;
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer with a stub ALU and an arithmetic reference model
module tb_alu_sequencer;
    logic        in_clk = 1'b0;
    logic        in_rst = 1'b1;
    logic        in_start = 1'b0;
    logic [3:0]  in_opcode = '0;
    logic [31:0] in_a = '0, in_b = '0;
    logic [31:0] out_alu_a, out_alu_b, out_alu_opcode, in_alu_result;
    logic        out_busy, out_done, out_div_by_zero;
    logic [31:0] out_hi, out_lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          nvec = 0, nerr = 0, cyc = 0;
    logic [64:0] hold = '0;

    alu_sequencer #(.WIDTH(32)) dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_start(in_start), .in_opcode(in_opcode),
        .in_a(in_a), .in_b(in_b), .out_alu_a(out_alu_a), .out_alu_b(out_alu_b),
        .out_alu_opcode(out_alu_opcode), .in_alu_result(in_alu_result),
        .out_busy(out_busy), .out_done(out_done), .out_hi(out_hi), .out_lo(out_lo),
        .out_div_by_zero(out_div_by_zero)
    );

    always #5 in_clk = ~in_clk;
    always @(posedge in_clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int s;
        s = int'(b[4:0]);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a >> s;
            4'd3:    return a << s;
            4'd4:    return (a >> s) | (a << (32 - s));
            4'd5:    return (a << s) | (a >> (32 - s));
            4'd6:    return a & b;
            4'd7:    return a | b;
            4'd10:   return -a;
            4'd11:   return ~a;
            default: return 32'h0;
        endcase
    endfunction

    always_comb in_alu_result = alu_model(out_alu_opcode[3:0], out_alu_a, out_alu_b);

    function automatic void ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo,
                                      output logic dbz, output int lat);
        longint p, q, r;
        dbz = 1'b0;
        if (op == 4'd8) begin
            p = longint'($signed(a)) * longint'($signed(b));
            hi = p[63:32];
            lo = p[31:0];
            lat = 32;
        end else if (op == 4'd9 && b == 0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
            dbz = 1'b1;
            lat = 0;
        end else if (op == 4'd9) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            hi = r[31:0];
            lo = q[31:0];
            lat = 32;
        end else begin
            hi = 32'h0;
            lo = alu_model(op, a, b);
            lat = 1;
        end
    endfunction

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare on every done pulse; otherwise results must hold
    always @(negedge in_clk) begin
        if (in_rst) begin
            sbq.delete();
            hold = '0;
        end else if (out_done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 65'(out_done), 65'(0));
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("result", {out_hi, out_lo, out_div_by_zero}, {e.hi, e.lo, e.dbz});
                chk("done_cycle", 65'(cyc), 65'(e.cyc));
                hold = {e.hi, e.lo, e.dbz};
            end
        end else begin
            chk("hold", {out_hi, out_lo, out_div_by_zero}, hold);
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold_start);
        logic [31:0] eh, el;
        logic        ed;
        int          lat, e, n;
        exp_t        x;
        n = 0;
        while (out_busy && n < 200) begin
            @(negedge in_clk);
            n++;
        end
        if (n >= 200) chk("busy_timeout", 65'(out_busy), 65'(0));
        in_start = 1'b1;
        in_opcode = op;
        in_a = a;
        in_b = b;
        @(posedge in_clk);
        #1;
        in_start = 1'b0;
        e = cyc;
        ref_model(op, a, b, eh, el, ed, lat);
        x.hi = eh;
        x.lo = el;
        x.dbz = ed;
        x.cyc = e + lat;
        sbq.push_back(x);
        chk("busy_after_accept", 65'(out_busy), 65'(lat != 0));
        if (lat == 1)
            chk("alu_ports", {1'b0, out_alu_opcode[3:0] == op && out_alu_opcode[31:4] == 0, out_alu_a, out_alu_b},
                {2'b01, a, b});
        if (hold_start && lat == 32) begin
            @(negedge in_clk);
            while (cyc < e + lat) begin
                in_start = 1'b1;
                in_opcode = 4'($urandom_range(0, 15));
                in_a = $urandom;
                in_b = $urandom;
                @(negedge in_clk);
            end
            in_start = 1'b0;
        end
    endtask

    initial begin
        #1;
        chk("reset_outputs", {out_busy, out_done, out_div_by_zero, out_hi, out_lo[29:0]}, 65'(0));
        chk("reset_alu_ports", {1'b0, out_alu_a, out_alu_b}, 65'(0));
        @(negedge in_clk);
        #1 in_rst = 1'b0;

        issue(4'd0, 32'd5, 32'd7, 0);
        issue(4'd8, 32'd7, 32'hFFFF_FFFD, 0);
        issue(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(4'd9, 32'hFFFF_FFF9, 32'd2, 0);
        issue(4'd9, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(4'd9, 32'h0000_1234, 32'd0, 0);
        issue(4'd0, 32'd1, 32'd2, 0);
        issue(4'd8, 32'h1234_5678, 32'h8765_4321, 1);
        issue(4'd9, 32'hDEAD_BEEF, 32'h0000_0013, 1);
        issue(4'd7, 32'hF0F0_0000, 32'h0000_0F0F, 0);
        issue(4'd9, 32'd9, 32'd0, 0);
        issue(4'd1, 32'd3, 32'd10, 0);

        issue(4'd8, 32'h0000_0ABC, 32'h0000_0DEF, 0);
        repeat (9) @(posedge in_clk);
        #2 in_rst = 1'b1;
        #1;
        chk("async_reset_mid_mul", {out_busy, out_done, out_div_by_zero, out_hi, out_lo[29:0]}, 65'(0));
        chk("async_reset_alu_ports", {1'b0, out_alu_a, out_alu_b}, 65'(0));
        @(negedge in_clk);
        #1 in_rst = 1'b0;
        repeat (40) @(negedge in_clk);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            issue(4'($urandom_range(0, 15)), a, b, $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0) @(negedge in_clk);
        end

        for (int n = 0; n < 100 && sbq.size() != 0; n++) @(negedge in_clk);
        chk("drain", 65'(sbq.size()), 65'(0));
        repeat (3) @(negedge in_clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle sequencer that sits between the Mini-SRC control unit and the combinational 32-bit ALU. It accepts one operation at a time through a start/busy/done handshake. Single-cycle opcodes go to the external ALU and the result is captured. MUL and DIV run in an internal iterative shift-add / restoring-divide engine that produces a 64-bit HI:LO result.

## Interface
Parameters:
- WIDTH, 32: operand width. Only 32 is supported; the counter and HI/LO are sized from it.

Ports:
- in_clk  input  1  single clock, rising-edge.
- in_rst  input  1  reset, asynchronous, active-high.
- in_start  input  1  request pulse; sampled only while out_busy=0.
- in_opcode  input  4  ALU opcode, same encoding as the ALU:
  - 0000 add, 0001 sub, 0010 shr, 0011 shl, 0100 ror, 0101 rol
  - 0110 and, 0111 or, 1000 mul, 1001 div, 1010 neg, 1011 not
- in_a  input  32  operand A (dividend for DIV).
- in_b  input  32  operand B (divisor for DIV).
- out_alu_a  output  32  registered operand to the external ALU.
- out_alu_b  output  32  registered operand to the external ALU.
- out_alu_opcode  output  32  registered opcode to the external ALU, zero-extended.
- in_alu_result  input  32  combinational result from the external ALU.
- out_busy  output  1  high in states ALU, MUL, DIV.
- out_done  output  1  one-cycle completion pulse.
- out_hi  output  32  MUL high word / DIV remainder / 0 for ALU ops.
- out_lo  output  32  MUL low word / DIV quotient / ALU result.
- out_div_by_zero  output  1  sticky flag for the last completed operation.

## Operation
- States: IDLE, ALU, MUL, DIV, DONE. out_busy=0 in IDLE and DONE.
- Accept: a start is taken on any edge where in_start=1 and state is IDLE or DONE. The accept edge latches in_a, in_b and in_opcode. A start seen while busy is ignored, with no queueing.
- Routing at accept:
  - 1000 → MUL, counter=31.
  - 1001 with in_b≠0 → DIV, counter=31.
  - 1001 with in_b=0 → DONE directly.
  - Every other opcode, including reserved 1100–1111 → ALU.
- ALU state:
  - out_alu_a, out_alu_b and out_alu_opcode present the latched values.
  - The next edge captures out_lo=in_alu_result, out_hi=0, out_div_by_zero=0, then goes to DONE.
- MUL (signed two's complement):
  - Form the magnitudes |a| and |b|.
  - Perform one shift-add step per cycle into a 64-bit accumulator.
  - On the step where counter=0, apply the sign (negate the 64-bit value if a[31]^b[31]). Write out_hi and out_lo, clear out_div_by_zero, go to DONE.
- DIV (signed, truncate toward zero):
  - Run a restoring divide on the magnitudes, one quotient bit per cycle.
  - The quotient is negated if a[31]^b[31]. The remainder takes the sign of a.
  - Write out_lo=quotient and out_hi=remainder at the final step.
  - -2^31 / -1 yields out_lo=0x80000000 and out_hi=0 (wraps, no flag).
- DIV by zero: out_lo=0xFFFFFFFF, out_hi=in_a, out_div_by_zero=1.
- DONE: out_done=1 for exactly one cycle. The next state is IDLE unless a new start is accepted on that edge.
- out_hi, out_lo and out_div_by_zero change only on completion edges and hold otherwise. out_alu_* hold their last values outside the ALU state.

## Timing
- Reset (async, immediate, independent of clock): state=IDLE, counter=0, and every output is 0. This covers out_busy, out_done, out_hi, out_lo, out_div_by_zero and out_alu_*.
- Reset mid-operation aborts it. No out_done is issued and prior results are cleared to 0.
- Latency is counted from the accept edge E to the cycle in which out_done=1:
  - ALU ops: out_done high in the cycle after E+1; result valid in that same cycle.
  - MUL, and DIV with nonzero divisor: 32 busy cycles; out_done high in the cycle after E+32.
  - DIV by zero: out_done high in the cycle after E; out_busy never rises.
- Back-to-back: a start during DONE is accepted, so the next out_busy rises with no idle gap. Issue rate is one ALU op per 2 cycles.
- out_busy rises the cycle after the accept edge and falls in the same cycle out_done rises.

## Test plan
- Reset: pulse in_rst asynchronously mid-MUL at cycle 10 → the same cycle shows out_busy=0 and out_hi=out_lo=0; no out_done follows.
- ALU path: drive a stub ALU model with opcode 0000, a=5, b=7 → out_alu_opcode=0 and out_alu_a/b=5/7 in the ALU state. Then out_lo=12, out_hi=0 and out_done pulse in the cycle after E+1.
- MUL signed: a=7, b=0xFFFFFFFD (-3) → out_hi=0xFFFFFFFF, out_lo=0xFFFFFFEB, with out_done in the cycle after E+32. Also a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0, lo=1.
- DIV signed and overflow:
  - a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIV by zero: a=0x1234, b=0 → the next cycle shows out_done=1, lo=0xFFFFFFFF, hi=0x1234 and out_div_by_zero=1. A following ADD clears the flag.
- Handshake:
  - in_start held high during a MUL → ignored; no result change until completion.
  - A start asserted in the DONE cycle → accepted, out_busy high on the next cycle, and exactly one out_done per accepted operation.
